// File: rtl/sdr_pkg.sv
// Shared SDR definitions: header defaults, sample width, sync FSM states and the hard slicer.
// Also used by the TX header inserter, so keep the defaults in step with it.
package sdr_pkg;

   localparam int unsigned SAMPLE_W        = 12;
   localparam int unsigned HDR_LEN_DEF     = 16;
   localparam logic [31:0] HDR_PATTERN_DEF = 32'hF0C3_A55A;
   localparam int unsigned PAYLOAD_LEN_DEF = 256;

   typedef enum logic {
      StSearch,
      StPayload
   } sync_state_e;

   // Hard decision per rail: sign bit, so 0 maps to bit 0. Result is {I, Q}.
   function automatic logic [1:0] slice_sym(input logic [SAMPLE_W-1:0] i,
                                            input logic [SAMPLE_W-1:0] q);
      return {i[SAMPLE_W-1], q[SAMPLE_W-1]};
   endfunction

endpackage

// File: rtl/qpsk_header_sync_if.sv
// Sample-in / symbol-out stream bundle for qpsk_header_sync.
// The slave modport is the sync block's view; master is the source/sink side.
interface qpsk_header_sync_if;
   import sdr_pkg::*;

   logic                in_valid;
   logic [SAMPLE_W-1:0] in_i;
   logic [SAMPLE_W-1:0] in_q;
   logic                in_ready;
   logic                out_valid;
   logic                out_i;
   logic                out_q;
   logic                out_last;
   logic                out_ready;
   logic                locked;

   modport slave (
      input  in_valid, in_i, in_q, out_ready,
      output in_ready, out_valid, out_i, out_q, out_last, locked
   );

   modport master (
      output in_valid, in_i, in_q, out_ready,
      input  in_ready, out_valid, out_i, out_q, out_last, locked
   );

endinterface

// File: rtl/header_correlator.sv
// Header history, fill counter and symbol-mismatch counter for the QPSK header search.
// Define QPSK_SYNC_SOFT_MATCH_EN to accept up to MAX_ERR mismatched symbols.
module header_correlator
   import sdr_pkg::*;
#(
   parameter int unsigned          HDR_LEN     = HDR_LEN_DEF,
   parameter logic [2*HDR_LEN-1:0] HDR_PATTERN = HDR_PATTERN_DEF,
   parameter int unsigned          MAX_ERR     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       shift,
   input  logic [1:0] sym,
   output logic       match
);

   localparam int unsigned HistW = 2 * HDR_LEN;
   localparam int unsigned FillW = $clog2(HDR_LEN + 1);

`ifdef QPSK_SYNC_SOFT_MATCH_EN
   localparam int unsigned ErrLimit = MAX_ERR;
`else
   // Exact match: the tolerance is forced to zero whatever MAX_ERR says.
   localparam int unsigned ErrLimit = MAX_ERR * 0;
`endif

   logic [HistW-1:0] hist_q, hist_d;
   logic [FillW-1:0] fill_q, fill_d;
   int unsigned      err_cnt;

   // Newest symbol enters at the top, so after HDR_LEN shifts symbol 0 sits in [1:0].
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift) begin
         hist_d = {sym, hist_q[HistW-1:2]};
         if (fill_q != FillW'(HDR_LEN)) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   always_comb begin
      err_cnt = 0;
      for (int k = 0; k < int'(HDR_LEN); k++) begin
         if (hist_d[2*k +: 2] != HDR_PATTERN[2*k +: 2]) begin
            err_cnt = err_cnt + 1;
         end
      end
   end

   // The symbol being accepted this cycle counts toward both fill and comparison.
   assign match = shift && !clear && (fill_q >= FillW'(HDR_LEN - 1)) && (err_cnt <= ErrLimit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/qpsk_header_sync.sv
// QPSK frame sync: hunt for the header, then slice PAYLOAD_LEN symbols onto a registered stream.
// Define QPSK_SYNC_SOFT_MATCH_EN to enable the MAX_ERR-tolerant header match.
module qpsk_header_sync
   import sdr_pkg::*;
#(
   parameter int unsigned          HDR_LEN     = HDR_LEN_DEF,
   parameter logic [2*HDR_LEN-1:0] HDR_PATTERN = HDR_PATTERN_DEF,
   parameter int unsigned          PAYLOAD_LEN = PAYLOAD_LEN_DEF,
   parameter int unsigned          MAX_ERR     = 1
) (
   input logic                clk,
   input logic                rst,
   qpsk_header_sync_if.slave  bus
);

   localparam logic [15:0] LastIdx = 16'(PAYLOAD_LEN - 1);

   sync_state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [1:0]  out_sym_q, out_sym_d;
   logic        out_last_q, out_last_d;
   logic        in_ready, accept, match, corr_shift, corr_clear;
   logic [1:0]  sym;

   header_correlator #(
      .HDR_LEN     (HDR_LEN),
      .HDR_PATTERN (HDR_PATTERN),
      .MAX_ERR     (MAX_ERR)
   ) u_corr (
      .clk   (clk),
      .rst   (rst),
      .clear (corr_clear),
      .shift (corr_shift),
      .sym   (sym),
      .match (match)
   );

   always_comb begin
      in_ready    = (state_q == StSearch) || !out_valid_q || bus.out_ready;
      accept      = bus.in_valid && in_ready;
      sym         = slice_sym(bus.in_i, bus.in_q);
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;
      corr_shift  = 1'b0;
      corr_clear  = 1'b0;

      // The output register drains in either state; a new load below overrides the drop.
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         StSearch: begin
            corr_shift = accept;
            if (match) begin
               state_d = StPayload;
               cnt_d   = '0;
            end
         end
         StPayload: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_sym_d   = sym;
               out_last_d  = (cnt_q == LastIdx);
               cnt_d       = cnt_q + 16'd1;
               if (cnt_q == LastIdx) begin
                  state_d    = StSearch;
                  cnt_d      = '0;
                  corr_clear = 1'b1;
               end
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StSearch;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_i     = out_sym_q[1];
   assign bus.out_q     = out_sym_q[0];
   assign bus.out_last  = out_last_q;
   assign bus.locked    = (state_q == StPayload);

endmodule

// File: tb/tb_qpsk_header_sync.sv
// Directed bench for qpsk_header_sync: frame reception, header errors, back-pressure,
// embedded headers, mid-frame reset and slicer boundaries.
module tb_qpsk_header_sync;

   localparam int unsigned PLEN = 256;
   localparam int unsigned HLEN = 16;
   localparam logic [31:0] HDR  = 32'hF0C3_A55A;
   localparam logic [11:0] POS  = 12'd1000;
   localparam logic [11:0] NEG  = 12'hC18;  // -1000

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qpsk_header_sync_if dif ();

   qpsk_header_sync #(
      .HDR_LEN     (16),
      .HDR_PATTERN (32'hF0C3_A55A),
      .PAYLOAD_LEN (256),
      .MAX_ERR     (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   int          tests = 0;
   int          fails = 0;
   logic [2:0]  exp_q[$];
   bit          stall_prev, silent, rdy_mode, pending_unlock;
   logic [2:0]  prev_out;
   int          cyc, hs_cnt;
   logic [11:0] pay_i[PLEN];
   logic [11:0] pay_q[PLEN];

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // One clock: check what the DUT shows, then drive this cycle's inputs.
   task automatic tick(input logic vi, input logic [11:0] si, input logic [11:0] sq,
                       output bit acc);
      logic       ready;
      logic [2:0] cur;
      @(negedge clk);
      cur = {dif.out_last, dif.out_i, dif.out_q};
      if (pending_unlock) begin
         check("locked_fall", dif.locked, 0);
         pending_unlock = 0;
      end
      if (silent) check("no_out_valid", dif.out_valid, 0);
      if (stall_prev) begin
         check("hold_valid", dif.out_valid, 1);
         check("hold_data", cur, prev_out);
      end
      if (dif.out_valid) begin
         if (exp_q.size() == 0) check("spurious_out", dif.out_valid, 0);
         else check($sformatf("out_sym_%0d", hs_cnt), cur, exp_q[0]);
      end
      ready = rdy_mode ? cyc[0] : 1'b1;
      dif.out_ready = ready;
      dif.in_valid  = vi;
      dif.in_i      = si;
      dif.in_q      = sq;
      #1;
      check("in_ready", dif.in_ready, (dif.locked && dif.out_valid && !ready) ? 0 : 1);
      acc = vi && dif.in_ready;
      if (dif.out_valid && ready && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         hs_cnt++;
      end
      stall_prev = dif.out_valid && !ready;
      prev_out   = cur;
      cyc++;
   endtask

   task automatic send_sym(input logic [11:0] si, input logic [11:0] sq, input bit pay,
                           input bit last);
      bit acc;
      int n;
      n = 0;
      do begin
         tick(1'b1, si, sq, acc);
         n++;
      end while (!acc && n < 64);
      if (!acc) check("accept_timeout", acc, 1);
      else if (pay) begin
         exp_q.push_back({last, si[11], sq[11]});
         if (last) pending_unlock = 1;
      end
   endtask

   task automatic send_frame(input int flip, input bit lock, input int n_pay);
      logic [31:0] h;
      logic [1:0]  b;
      h = HDR;
      for (int k = 0; k < int'(HLEN); k++) begin
         b = h[2*k +: 2];
         if (k == flip) b[1] = ~b[1];
         send_sym(b[1] ? NEG : POS, b[0] ? NEG : POS, 1'b0, 1'b0);
      end
      for (int n = 0; n < n_pay; n++) begin
         send_sym(pay_i[n], pay_q[n], lock, lock && (n == int'(PLEN) - 1));
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while ((exp_q.size() > 0 || dif.out_valid) && n < 400) begin
         tick(1'b0, 12'd0, 12'd0, acc);
         n++;
      end
      tick(1'b0, 12'd0, 12'd0, acc);
      check("drain_done", exp_q.size(), 0);
   endtask

   // kind 0: random, 1: all +1000, 2: random with header at 100, 3: random with slicer edges
   task automatic gen_payload(input int kind);
      logic [31:0] v, h;
      logic [1:0]  b;
      h = HDR;
      for (int n = 0; n < int'(PLEN); n++) begin
         v = $urandom;
         pay_i[n] = (kind == 1) ? POS : v[11:0];
         pay_q[n] = (kind == 1) ? POS : v[27:16];
      end
      if (kind == 2) begin
         for (int k = 0; k < int'(HLEN); k++) begin
            b = h[2*k +: 2];
            pay_i[100+k] = b[1] ? NEG : POS;
            pay_q[100+k] = b[0] ? NEG : POS;
         end
      end
      if (kind == 3) begin
         pay_i[0] = 12'd0;   pay_q[0] = 12'hFFF;
         pay_i[1] = 12'h800; pay_q[1] = 12'h7FF;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      dif.in_valid  = 1'b0;
      dif.in_i      = '0;
      dif.in_q      = '0;
      dif.out_ready = 1'b1;
      rst = 1'b1;
      #2;
      check("rst_out_valid", dif.out_valid, 0);
      check("rst_out_i", dif.out_i, 0);
      check("rst_out_q", dif.out_q, 0);
      check("rst_out_last", dif.out_last, 0);
      check("rst_locked", dif.locked, 0);
      check("rst_in_ready", dif.in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Clean frame with slicer boundary symbols at payload 0 and 1.
      gen_payload(3);
      hs_cnt = 0;
      send_frame(-1, 1'b1, PLEN);
      drain();
      check("frame_a_count", hs_cnt, PLEN);
      check("frame_a_unlocked", dif.locked, 0);

      // Header with one flipped symbol.
      gen_payload(1);
      hs_cnt = 0;
`ifdef QPSK_SYNC_SOFT_MATCH_EN
      send_frame(3, 1'b1, PLEN);
      drain();
      check("flip_soft_count", hs_cnt, PLEN);
`else
      silent = 1;
      send_frame(3, 1'b0, PLEN);
      drain();
      silent = 0;
      check("flip_exact_count", hs_cnt, 0);
      check("flip_exact_locked", dif.locked, 0);
`endif

      // Alternating out_ready back-pressure.
      gen_payload(0);
      hs_cnt   = 0;
      rdy_mode = 1;
      send_frame(-1, 1'b1, PLEN);
      drain();
      rdy_mode = 0;
      check("toggle_count", hs_cnt, PLEN);

      // Header copy embedded in the payload must not restart or re-lock.
      gen_payload(2);
      hs_cnt = 0;
      send_frame(-1, 1'b1, PLEN);
      drain();
      check("embed_count", hs_cnt, PLEN);
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 12'd0, 12'd0, acc);
         check("embed_no_relock", dif.locked, 0);
      end

      // Reset during payload symbol 50, then a full frame.
      gen_payload(0);
      hs_cnt = 0;
      send_frame(-1, 1'b1, 50);
      @(posedge clk);
      #1;
      check("pre_rst_valid", dif.out_valid, 1);
      check("pre_rst_locked", dif.locked, 1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", dif.out_valid, 0);
      check("mid_rst_locked", dif.locked, 0);
      check("mid_rst_out_last", dif.out_last, 0);
      check("mid_rst_out_iq", {dif.out_i, dif.out_q}, 0);
      check("mid_rst_in_ready", dif.in_ready, 1);
      exp_q.delete();
      stall_prev     = 0;
      pending_unlock = 0;
      @(negedge clk);
      rst = 1'b0;
      gen_payload(0);
      hs_cnt = 0;
      send_frame(-1, 1'b1, PLEN);
      drain();
      check("post_rst_count", hs_cnt, PLEN);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
